uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1 by default, driven by the board's RX pin. It recovers each byte and presents it on `data` with a single-cycle `ready` strobe. It sits directly upstream of the LED/command consumers, which sample `data` only when `ready` is high. It also flags stop-bit (framing) errors and, optionally, parity errors.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rx_sync.sv | 23 ++
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states and constants for the uart_rx serial receiver
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 104;
    localparam int DATA_BITS            = 8;

endpackage

// File: rtl/rx_sync.sv
// rtl/rx_sync.sv - 1-bit two-flop synchronizer with configurable reset value
module rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver; define UART_RX_PARITY_EN for an even-parity bit
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       ready,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    rx_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [7:0]    data_nxt;
    logic          ready_nxt, ferr_nxt;
    logic          rx_s;
    logic          half_done, bit_done;

    rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign half_done = (cnt == HALF_LAST);
    assign bit_done  = (cnt == BIT_LAST);

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_bit_nxt, perr_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data      <= '0;
            ready     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            shreg     <= shreg_nxt;
            data      <= data_nxt;
            ready     <= ready_nxt;
            frame_err <= ferr_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bit    <= par_bit_nxt;
            parity_err <= perr_nxt;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        shreg_nxt = shreg;
        data_nxt  = data;
        ready_nxt = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt = par_bit;
        perr_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (half_done) begin
                    cnt_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {rx_s, shreg[7:1]};
                    idx_nxt   = idx + IW'(1);
                    if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    cnt_nxt     = '0;
                    par_bit_nxt = rx_s;
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        data_nxt  = shreg;
                        ready_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_nxt  = (^shreg) != par_bit;
`endif
                        state_nxt = IDLE;
                    end else begin
                        // Bad stop bit: keep last good byte and wait out the low line
                        ferr_nxt  = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at CLKS_PER_BIT=8
module tb_uart_rx;

    localparam int CPB  = 8;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       perr;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       frame_err;
    logic       parity_err;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .ready      (ready),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // kind: 0 = no output expected, 1 = ready, 2 = frame_err
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                               input int kind, input logic [7:0] exp_data, input logic exp_perr);
        exp_t e;
        if (kind != 0) begin
            e.kind = kind;
            e.data = exp_data;
            e.perr = exp_perr;
            e.cyc  = cyc + 3 + HALF + NB * CPB;
            q.push_back(e);
        end
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (ready || frame_err || parity_err) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: ready=%0b frame_err=%0b parity_err=%0b, expected none (cycle %0d)",
                         ready, frame_err, parity_err, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("kind", ready ? 1 : (frame_err ? 2 : 0), e.kind);
                check("both_strobes", int'(ready && frame_err), 0);
                check("data", int'(data), int'(e.data));
                check("parity_err", int'(parity_err), int'(e.perr));
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int wait_cnt;
        repeat (3) @(negedge clk);
        check("reset_data", int'(data), 0);
        check("reset_ready", int'(ready), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_parity_err", int'(parity_err), 0);
        reset = 1'b0;
        idle(5);

        drive_frame(8'h31, 1'b1, 1'b0, 1, 8'h31, 1'b0);
        idle(10);

        drive_frame(8'h55, 1'b1, 1'b0, 1, 8'h55, 1'b0);
        drive_frame(8'hAA, 1'b1, 1'b0, 1, 8'hAA, 1'b0);
        idle(10);

        rx = 1'b0;
        repeat (2) @(negedge clk);
        idle(20);
        drive_frame(8'h42, 1'b1, 1'b0, 1, 8'h42, 1'b0);
        idle(10);

        drive_frame(8'h41, 1'b0, 1'b0, 2, 8'h42, 1'b0);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        idle(20);
`ifdef UART_RX_PARITY_EN
        drive_frame(8'h33, 1'b1, 1'b1, 1, 8'h33, 1'b1);
`else
        drive_frame(8'h33, 1'b1, 1'b0, 1, 8'h33, 1'b0);
`endif
        idle(10);

        // Bits 4..7 of 0xF0 are high, so the aborted tail cannot look like a new start
        fork
            drive_frame(8'hF0, 1'b1, 1'b0, 0, 8'h00, 1'b0);
            begin
                repeat (5 * CPB + HALF) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("midframe_reset_data", int'(data), 0);
                check("midframe_reset_ready", int'(ready), 0);
                check("midframe_reset_frame_err", int'(frame_err), 0);
            end
        join
        idle(20);
        drive_frame(8'h35, 1'b1, 1'b0, 1, 8'h35, 1'b0);
        idle(10);

        wait_cnt = 0;
        while (q.size() != 0 && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("pending_expectations", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
